// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c byte engine between NREQ requesters,
// with NACK retry, a per-attempt watchdog and a one-cycle response pulse.
module i2c_arbiter #(
    parameter  int NREQ      = 3,
    parameter  int NBYTES    = 3,
    parameter  int MAX_RETRY = 2,
    parameter  int TIMEOUT   = 2_000_000,
    localparam int NBW       = $clog2(NBYTES + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*NBW-1:0]      req_nbytes_i,
    input  logic [NREQ*NBYTES*8-1:0] req_data_i,
    output logic [NREQ-1:0]          grant_o,
    output logic [NREQ-1:0]          ack_o,
    output logic [NBYTES-1:0]        rsp_status_o,
    output logic [1:0]               rsp_err_o,
    output logic                     busy_o,
    output logic                     send_o,
    output logic [NBW-1:0]           nbytes_o,
    output logic [NBYTES*8-1:0]      data_o,
    input  logic                     ready_i,
    input  logic                     done_i,
    input  logic [NBYTES-1:0]        status_i
);
    localparam int          RW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          DW  = NBYTES * 8;
    localparam int          WDW = $clog2(TIMEOUT);
    localparam int          RTW = $clog2(MAX_RETRY + 2);
    localparam int unsigned NR  = NREQ;
    localparam int unsigned NB  = NBYTES;
    // The counter is compared one step early so that ack_o lands TIMEOUT cycles after send_o.
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 2);
    localparam logic [RTW-1:0] RETRY_MAX = RTW'(MAX_RETRY);
    localparam logic [RW-1:0]  LAST_RST  = RW'(NREQ - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, RESP} state_t;

    state_t            state_q;
    logic [RW-1:0]     last_q;
    logic [RTW-1:0]    retry_q;
    logic [WDW-1:0]    wdog_q;
    logic              bad_q;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   ack_q;
    logic [NBYTES-1:0] status_q;
    logic [1:0]        err_q;
    logic              send_q;
    logic [NBW-1:0]    nbytes_q;
    logic [DW-1:0]     data_q;

    logic              win_vld_d;
    logic [RW-1:0]     win_d;
    logic [NBW-1:0]    win_nbytes_d;
    logic [DW-1:0]     win_data_d;
    logic              win_bad_d;
    logic [NBYTES-1:0] mask_d;
    logic              all_ack_d;

    always_comb begin
        win_vld_d = 1'b0;
        win_d     = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            int unsigned idx;
            idx = (32'(last_q) + k) % NR;
            if (!win_vld_d && req_i[idx]) begin
                win_vld_d = 1'b1;
                win_d     = RW'(idx);
            end
        end
        win_nbytes_d = req_nbytes_i[win_d*NBW +: NBW];
        win_data_d   = req_data_i[win_d*DW +: DW];
        win_bad_d    = (win_nbytes_d == '0) || (win_nbytes_d > NBW'(NBYTES));
        mask_d       = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            mask_d[k] = (k < 32'(nbytes_q));
        end
        all_ack_d = ((status_i & mask_d) == mask_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            retry_q  <= '0;
            wdog_q   <= '0;
            bad_q    <= 1'b0;
            grant_q  <= '0;
            ack_q    <= '0;
            status_q <= '0;
            err_q    <= '0;
            send_q   <= 1'b0;
            nbytes_q <= '0;
            data_q   <= '0;
        end else begin
            send_q <= 1'b0;
            ack_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (ready_i && win_vld_d) begin
                        grant_q  <= NREQ'(1) << win_d;
                        last_q   <= win_d;
                        nbytes_q <= win_nbytes_d;
                        data_q   <= win_data_d;
                        retry_q  <= '0;
                        status_q <= '0;
                        err_q    <= '0;
                        bad_q    <= win_bad_d;
                        send_q   <= !win_bad_d;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_q <= '0;
                    if (bad_q) begin
                        err_q   <= 2'b11;
                        ack_q   <= grant_q;
                        state_q <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (wdog_q != '1) wdog_q <= wdog_q + 1'b1;
                    if (done_i) begin
                        status_q <= status_i;
                        if (all_ack_d) begin
                            err_q   <= 2'b00;
                            ack_q   <= grant_q;
                            state_q <= RESP;
                        end else if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= HOLD;
                        end else begin
                            err_q   <= 2'b01;
                            ack_q   <= grant_q;
                            state_q <= RESP;
                        end
                    end else if (wdog_q == WD_LAST) begin
                        err_q   <= 2'b10;
                        ack_q   <= grant_q;
                        state_q <= RESP;
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        send_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                RESP: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign ack_o        = ack_q;
    assign rsp_status_o = status_q;
    assign rsp_err_o    = err_q;
    assign busy_o       = (state_q != IDLE);
    assign send_o       = send_q;
    assign nbytes_o     = nbytes_q;
    assign data_o       = data_q;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: a behavioural engine plus an arbitration/outcome model
// drive randomized and directed transactions and check every response.
module tb_i2c_arbiter;
    localparam int NREQ      = 3;
    localparam int NBYTES    = 3;
    localparam int MAX_RETRY = 2;
    localparam int TIMEOUT   = 100;
    localparam int NBW       = $clog2(NBYTES + 1);
    localparam int DW        = NBYTES * 8;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic [NREQ-1:0]        req_i;
    logic [NREQ*NBW-1:0]    req_nbytes_i;
    logic [NREQ*DW-1:0]     req_data_i;
    logic [NREQ-1:0]        grant_o;
    logic [NREQ-1:0]        ack_o;
    logic [NBYTES-1:0]      rsp_status_o;
    logic [1:0]             rsp_err_o;
    logic                   busy_o;
    logic                   send_o;
    logic [NBW-1:0]         nbytes_o;
    logic [DW-1:0]          data_o;
    logic                   ready_i;
    logic                   done_i;
    logic [NBYTES-1:0]      status_i;

    i2c_arbiter #(.NREQ(NREQ), .NBYTES(NBYTES), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_nbytes_i(req_nbytes_i),
        .req_data_i(req_data_i), .grant_o(grant_o), .ack_o(ack_o),
        .rsp_status_o(rsp_status_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .send_o(send_o), .nbytes_o(nbytes_o), .data_o(data_o), .ready_i(ready_i),
        .done_i(done_i), .status_i(status_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int model_last;

    logic [NBYTES-1:0] eng_st [0:MAX_RETRY];

    logic              obs_hit, obs_first_send, obs_grant_ok, obs_data_ok;
    logic [NREQ-1:0]   obs_grant, obs_ack, obs_ack_after, obs_grant_after;
    logic [1:0]        obs_err;
    logic [NBYTES-1:0] obs_status;
    logic [DW-1:0]     obs_data;
    logic [NBW-1:0]    obs_nbytes;
    int                obs_sends, obs_ack_step, obs_send_to_ack, obs_done_to_ack, obs_gap;

    function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic model_outcome(input int nb, output int n_att, output logic [1:0] err,
                                 output logic [NBYTES-1:0] fst);
        int mask;
        n_att = 0; err = 2'b11; fst = '0;
        if (nb == 0 || nb > NBYTES) return;
        mask = (1 << nb) - 1;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            n_att = a + 1;
            fst   = eng_st[a];
            if ((int'(eng_st[a]) & mask) == mask) begin
                err = 2'b00;
                return;
            end
        end
        err = 2'b01;
    endtask

    task automatic set_slot(input int r, input int nb, input logic [DW-1:0] d);
        req_nbytes_i[r*NBW +: NBW] = NBW'(nb);
        req_data_i[r*DW +: DW]     = d;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_i = 1'b1; req_i = '0; ready_i = 1'b1; done_i = 1'b0; status_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        model_last = NREQ - 1;
    endtask

    // Engine model: answers each send_o after lat cycles (first n_respond attempts
    // only), keeping ready_i low until hgap cycles after done_i.
    task automatic engine_txn(input int n_respond, input int lat, input int hgap,
                              input bit scramble, input int bound);
        int step = 0, cd = 0, rc = 0, attempt = 0, last_send = 0, last_done = 0;
        logic [NREQ-1:0] g0 = '0;
        obs_hit = 0; obs_first_send = 0; obs_grant_ok = 1; obs_data_ok = 1;
        obs_sends = 0; obs_gap = -1; obs_ack = '0; obs_err = '0; obs_status = '0;
        obs_data = '0; obs_nbytes = '0; obs_ack_step = -1; obs_send_to_ack = -1;
        obs_done_to_ack = -1; obs_grant = '0; obs_ack_after = '1; obs_grant_after = '1;
        ready_i = 1'b1; done_i = 1'b0;
        while (!obs_hit && step < bound) begin
            @(negedge clk);
            step++;
            done_i = 1'b0;
            if (step == 1) begin
                g0 = grant_o; obs_grant = grant_o; obs_first_send = send_o;
            end
            if (grant_o !== g0 || grant_o == '0) obs_grant_ok = 0;
            if (ack_o != '0) begin
                obs_hit = 1; obs_ack = ack_o; obs_err = rsp_err_o; obs_status = rsp_status_o;
                obs_ack_step = step; obs_send_to_ack = step - last_send;
                obs_done_to_ack = step - last_done;
            end else if (send_o) begin
                if (obs_sends == 0) begin
                    obs_data = data_o; obs_nbytes = nbytes_o;
                end else begin
                    if (data_o !== obs_data || nbytes_o !== obs_nbytes) obs_data_ok = 0;
                    obs_gap = step - last_done;
                end
                obs_sends++; last_send = step; ready_i = 1'b0; cd = lat;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && attempt < n_respond) begin
                    done_i = 1'b1; status_i = eng_st[attempt]; attempt++; last_done = step;
                    if (hgap == 0) ready_i = 1'b1; else rc = hgap;
                end
            end else if (rc > 0) begin
                rc--;
                if (rc == 0) ready_i = 1'b1;
            end
            if (scramble && step == 1) begin
                req_nbytes_i = (NREQ*NBW)'($urandom);
                req_data_i   = (NREQ*DW)'({$urandom, $urandom, $urandom});
            end
        end
        if (obs_hit) begin
            @(negedge clk);
            obs_ack_after = ack_o; obs_grant_after = grant_o;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (grant_o !== '0 || ack_o !== '0) $display("FAIL reset_grant_ack: got %b/%b want 0/0", grant_o, ack_o); else n_pass++;
        n_checks++; if (send_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL reset_send_busy: got %b/%b want 0/0", send_o, busy_o); else n_pass++;
        n_checks++; if ({nbytes_o, data_o, rsp_status_o, rsp_err_o} !== '0) $display("FAIL reset_data: got nb=%0d data=%h st=%b err=%b want all 0", nbytes_o, data_o, rsp_status_o, rsp_err_o); else n_pass++;
    endtask

    task automatic test_single();
        set_slot(1, 2, 24'h720835);
        eng_st[0] = 3'b111;
        req_i = 3'b010;
        model_last = 1;
        engine_txn(1, 2, 0, 1'b0, 100);
        req_i = '0;
        n_checks++; if (obs_hit !== 1'b1) $display("FAIL single_ack_seen: got none want ack"); else n_pass++;
        n_checks++; if (obs_first_send !== 1'b1 || obs_grant !== 3'b010) $display("FAIL single_latency: got send=%b grant=%b want 1/010", obs_first_send, obs_grant); else n_pass++;
        n_checks++; if (obs_sends !== 1) $display("FAIL single_sends: got %0d want 1", obs_sends); else n_pass++;
        n_checks++; if (obs_data !== 24'h720835 || obs_nbytes !== 2'd2) $display("FAIL single_payload: got %h/%0d want 720835/2", obs_data, obs_nbytes); else n_pass++;
        n_checks++; if (obs_ack !== 3'b010 || obs_err !== 2'b00) $display("FAIL single_rsp: got ack=%b err=%b want 010/00", obs_ack, obs_err); else n_pass++;
        n_checks++; if (obs_done_to_ack !== 1 || obs_ack_after !== '0) $display("FAIL single_ack_timing: got d2a=%0d after=%b want 1/000", obs_done_to_ack, obs_ack_after); else n_pass++;
        n_checks++; if (obs_status !== 3'b111 || obs_grant_after !== '0) $display("FAIL single_status: got %b grant_after=%b want 111/000", obs_status, obs_grant_after); else n_pass++;
    endtask

    task automatic test_round_robin();
        int owner;
        logic [NREQ-1:0] oh;
        logic [DW-1:0] ds [NREQ];
        int nbs [NREQ];
        apply_reset();
        for (int s = 0; s < NREQ; s++) begin
            nbs[s] = $urandom_range(1, NBYTES); ds[s] = DW'($urandom); set_slot(s, nbs[s], ds[s]);
        end
        for (int a = 0; a <= MAX_RETRY; a++) eng_st[a] = '1;
        req_i = '1;
        for (int t = 0; t < 6; t++) begin
            owner = model_pick(req_i, model_last); model_last = owner;
            oh = NREQ'(1) << owner;
            engine_txn(1, $urandom_range(1, 3), 0, 1'b0, 100);
            n_checks++; if (obs_grant !== oh || obs_ack !== oh) $display("FAIL rr_owner[%0d]: got grant=%b ack=%b want %b", t, obs_grant, obs_ack, oh); else n_pass++;
            n_checks++; if (obs_data !== ds[owner] || obs_nbytes !== NBW'(nbs[owner])) $display("FAIL rr_payload[%0d]: got %h/%0d want %h/%0d", t, obs_data, obs_nbytes, ds[owner], nbs[owner]); else n_pass++;
            n_checks++; if (obs_first_send !== 1'b1 || obs_ack_after !== '0) $display("FAIL rr_back_to_back[%0d]: got send=%b after=%b want 1/000", t, obs_first_send, obs_ack_after); else n_pass++;
        end
        req_i = '0;
    endtask

    task automatic test_retry();
        int owner;
        logic [NREQ-1:0] oh;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            owner = $urandom_range(0, NREQ - 1);
            oh = NREQ'(1) << owner;
            set_slot(owner, 3, DW'($urandom));
            eng_st[0] = 3'b101; eng_st[1] = 3'b101; eng_st[2] = (pass == 0) ? 3'b111 : 3'b101;
            model_last = owner;
            req_i = oh;
            engine_txn(3, 2, 2, 1'b0, 200);
            req_i = '0;
            n_checks++; if (obs_sends !== 3) $display("FAIL retry_sends[%0d]: got %0d want 3", pass, obs_sends); else n_pass++;
            n_checks++; if (obs_err !== ((pass == 0) ? 2'b00 : 2'b01) || obs_ack !== oh) $display("FAIL retry_err[%0d]: got err=%b ack=%b want %b/%b", pass, obs_err, obs_ack, (pass == 0) ? 2'b00 : 2'b01, oh); else n_pass++;
            n_checks++; if (obs_status !== eng_st[2]) $display("FAIL retry_status[%0d]: got %b want %b", pass, obs_status, eng_st[2]); else n_pass++;
            n_checks++; if (obs_gap !== 3 || obs_data_ok !== 1'b1) $display("FAIL retry_gap[%0d]: got gap=%0d same_payload=%b want 3/1", pass, obs_gap, obs_data_ok); else n_pass++;
        end
    endtask

    task automatic test_bad_length();
        int owner;
        logic [NREQ-1:0] oh;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            owner = $urandom_range(0, NREQ - 1);
            oh = NREQ'(1) << owner;
            set_slot(owner, 0, DW'($urandom));
            model_last = owner;
            req_i = oh;
            engine_txn(1, 1, 0, 1'b0, 50);
            req_i = '0;
            n_checks++; if (obs_ack_step !== 2 || obs_ack !== oh) $display("FAIL badlen_ack[%0d]: got step=%0d ack=%b want 2/%b", pass, obs_ack_step, obs_ack, oh); else n_pass++;
            n_checks++; if (obs_err !== 2'b11 || obs_sends !== 0) $display("FAIL badlen_err[%0d]: got err=%b sends=%0d want 11/0", pass, obs_err, obs_sends); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int owner;
        logic [NREQ-1:0] r, oh;
        bit quiet;
        @(negedge clk);
        r = NREQ'(1) << $urandom_range(0, NREQ - 1);
        owner = model_pick(r, model_last); model_last = owner; oh = NREQ'(1) << owner;
        set_slot(owner, NBYTES, DW'($urandom));
        req_i = r;
        engine_txn(0, 1, 0, 1'b0, 400);
        req_i = '0;
        n_checks++; if (obs_hit !== 1'b1 || obs_err !== 2'b10 || obs_ack !== oh) $display("FAIL timeout_rsp: got hit=%b err=%b ack=%b want 1/10/%b", obs_hit, obs_err, obs_ack, oh); else n_pass++;
        n_checks++; if (obs_send_to_ack !== TIMEOUT || obs_sends !== 1) $display("FAIL timeout_latency: got %0d sends=%0d want %0d/1", obs_send_to_ack, obs_sends, TIMEOUT); else n_pass++;
        do r = NREQ'($urandom); while (r == '0);
        for (int s = 0; s < NREQ; s++) set_slot(s, $urandom_range(1, NBYTES), DW'($urandom));
        req_i = r;
        quiet = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (send_o !== 1'b0 || grant_o !== '0) quiet = 0;
        end
        n_checks++; if (quiet !== 1'b1) $display("FAIL timeout_blocks: got activity while ready_i low want none"); else n_pass++;
        owner = model_pick(r, model_last); model_last = owner; oh = NREQ'(1) << owner;
        for (int a = 0; a <= MAX_RETRY; a++) eng_st[a] = '1;
        engine_txn(1, 2, 0, 1'b0, 100);
        req_i = '0;
        n_checks++; if (obs_first_send !== 1'b1 || obs_grant !== oh || obs_err !== 2'b00) $display("FAIL timeout_recover: got send=%b grant=%b err=%b want 1/%b/00", obs_first_send, obs_grant, obs_err, oh); else n_pass++;
        @(negedge clk);
        r = NREQ'(1) << $urandom_range(0, NREQ - 1);
        owner = model_pick(r, model_last); model_last = owner;
        set_slot(owner, NBYTES, DW'($urandom));
        req_i = r;
        engine_txn(1, TIMEOUT - 1, 0, 1'b0, 400);
        req_i = '0;
        n_checks++; if (obs_err !== 2'b00 || obs_status !== '1 || obs_done_to_ack !== 1) $display("FAIL timeout_coincide: got err=%b st=%b d2a=%0d want 00/111/1", obs_err, obs_status, obs_done_to_ack); else n_pass++;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r, oh;
        int owner, n_att;
        int nbs [NREQ];
        logic [DW-1:0] ds [NREQ];
        logic [1:0] eerr;
        logic [NBYTES-1:0] est;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            do r = NREQ'($urandom); while (r == '0);
            for (int s = 0; s < NREQ; s++) begin
                nbs[s] = $urandom_range(0, NBYTES); ds[s] = DW'($urandom); set_slot(s, nbs[s], ds[s]);
            end
            for (int a = 0; a <= MAX_RETRY; a++) eng_st[a] = ($urandom_range(0, 1) == 1) ? '1 : NBYTES'($urandom);
            owner = model_pick(r, model_last); model_last = owner; oh = NREQ'(1) << owner;
            model_outcome(nbs[owner], n_att, eerr, est);
            req_i = r;
            engine_txn(MAX_RETRY + 1, $urandom_range(1, 4), $urandom_range(0, 2), 1'b1, 300);
            req_i = '0;
            n_checks++; if (obs_ack !== oh || obs_grant !== oh || obs_grant_ok !== 1'b1) $display("FAIL rand_owner[%0d]: got ack=%b grant=%b held=%b want %b", t, obs_ack, obs_grant, obs_grant_ok, oh); else n_pass++;
            n_checks++; if (obs_err !== eerr || obs_sends !== n_att) $display("FAIL rand_outcome[%0d]: got err=%b sends=%0d want %b/%0d", t, obs_err, obs_sends, eerr, n_att); else n_pass++;
            n_checks++; if (obs_ack_after !== '0 || obs_grant_after !== '0) $display("FAIL rand_release[%0d]: got ack=%b grant=%b want 000/000", t, obs_ack_after, obs_grant_after); else n_pass++;
            if (nbs[owner] != 0) begin
                n_checks++; if (obs_status !== est || obs_done_to_ack !== 1) $display("FAIL rand_status[%0d]: got %b d2a=%0d want %b/1", t, obs_status, obs_done_to_ack, est); else n_pass++;
                n_checks++; if (obs_data !== ds[owner] || obs_nbytes !== NBW'(nbs[owner]) || obs_data_ok !== 1'b1) $display("FAIL rand_payload[%0d]: got %h/%0d same=%b want %h/%0d", t, obs_data, obs_nbytes, obs_data_ok, ds[owner], nbs[owner]); else n_pass++;
            end else begin
                n_checks++; if (obs_ack_step !== 2) $display("FAIL rand_badlen[%0d]: got step=%0d want 2", t, obs_ack_step); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [NREQ-1:0] oh;
        bit no_ack;
        apply_reset();
        set_slot(1, 3, DW'($urandom));
        req_i = 3'b010;
        @(negedge clk);
        n_checks++; if (send_o !== 1'b1) $display("FAIL rmw_send: got %b want 1", send_o); else n_pass++;
        ready_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy_o !== 1'b1) $display("FAIL rmw_busy: got %b want 1", busy_o); else n_pass++;
        rst_i = 1'b1;
        @(negedge clk);
        n_checks++; if ({grant_o, ack_o, send_o, busy_o, nbytes_o, data_o, rsp_status_o, rsp_err_o} !== '0) $display("FAIL rmw_outputs: got grant=%b ack=%b send=%b busy=%b nb=%0d err=%b want all 0", grant_o, ack_o, send_o, busy_o, nbytes_o, rsp_err_o); else n_pass++;
        rst_i = 1'b0; ready_i = 1'b1; model_last = NREQ - 1;
        for (int s = 0; s < NREQ; s++) set_slot(s, 1, DW'($urandom));
        req_i = '1;
        oh = NREQ'(1) << model_pick(req_i, model_last);
        no_ack = 1;
        @(negedge clk);
        if (ack_o !== '0) no_ack = 0;
        n_checks++; if (grant_o !== oh) $display("FAIL rmw_restart: got grant=%b want %b", grant_o, oh); else n_pass++;
        repeat (3) begin
            @(negedge clk);
            if (ack_o !== '0) no_ack = 0;
        end
        n_checks++; if (no_ack !== 1'b1) $display("FAIL rmw_no_ack: got ack after reset want none"); else n_pass++;
        apply_reset();
    endtask

    initial begin
        rst_i = 1'b1; req_i = '0; req_nbytes_i = '0; req_data_i = '0;
        ready_i = 1'b1; done_i = 1'b0; status_i = '0; model_last = NREQ - 1;
        test_reset();
        test_single();
        test_round_robin();
        test_retry();
        test_bad_length();
        test_timeout();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no completion want summary before 2ms");
        $fatal(1);
    end
endmodule
